// File: rtl/bus_arbiter.sv
// Two-initiator serial bus arbiter/sequencer: grants one initiator, tracks address/data phases.
// Define ARB_TIMEOUT_EN to abort stalled transactions after TIMEOUT_CYCLES idle cycles.
module bus_arbiter #(
    parameter int ADDR_BITS = 16,
    parameter int DATA_BITS = 8
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 256
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic m1_req,
    input  logic m2_req,
    input  logic m1_rw,
    input  logic m2_rw,
    input  logic bus_m_valid,
    input  logic bus_s_valid,
    input  logic bus_s_ready,
    input  logic bus_s_ack,
    output logic m1_grant,
    output logic m2_grant,
    output logic bus_mode,
    output logic m1_done,
    output logic m2_done,
    output logic arb_err,
    output logic busy
);

    localparam int CW = $clog2(ADDR_BITS + 1);

    typedef enum logic [2:0] {IDLE, ADDR, WDATA, RDATA, WAIT_ACK, DONE} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  bitCnt_q, bitCnt_d;
    logic           rw_q, rw_d;
    logic           ownerM2_q, ownerM2_d;
    logic           lastM2_q, lastM2_d;
    logic           m1Grant_q, m1Grant_d;
    logic           m2Grant_q, m2Grant_d;
    logic           mode_q, mode_d;
    logic           m1Done_q, m1Done_d;
    logic           m2Done_q, m2Done_d;
    logic           err_q, err_d;
    logic           busy_q, busy_d;
    logic           abort;

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]  tmo_q, tmo_d;
    logic           progress;

    // Any counted strobe or ack restarts the stall window.
    always_comb begin
        progress = ((state_q == ADDR)     && bus_m_valid) ||
                   ((state_q == WDATA)    && bus_m_valid) ||
                   ((state_q == RDATA)    && bus_s_valid && bus_s_ready) ||
                   ((state_q == WAIT_ACK) && bus_s_ack);
        abort    = (state_q inside {ADDR, WDATA, RDATA, WAIT_ACK}) && !progress &&
                   (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    end
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        bitCnt_d  = bitCnt_q;
        rw_d      = rw_q;
        ownerM2_d = ownerM2_q;
        lastM2_d  = lastM2_q;

        case (state_q)
            IDLE: begin
                // On a tie the initiator that did not own the bus last time wins.
                if (m1_req && (!m2_req || lastM2_q)) begin
                    ownerM2_d = 1'b0;
                    rw_d      = m1_rw;
                    state_d   = ADDR;
                end else if (m2_req) begin
                    ownerM2_d = 1'b1;
                    rw_d      = m2_rw;
                    state_d   = ADDR;
                end
            end
            ADDR: begin
                if (bus_m_valid) begin
                    if (bitCnt_q == CW'(ADDR_BITS - 1))
                        state_d = rw_q ? WDATA : RDATA;
                    else
                        bitCnt_d = bitCnt_q + 1'b1;
                end
            end
            WDATA: begin
                if (bus_m_valid) begin
                    if (bitCnt_q == CW'(DATA_BITS - 1))
                        state_d = WAIT_ACK;
                    else
                        bitCnt_d = bitCnt_q + 1'b1;
                end
            end
            RDATA: begin
                if (bus_s_valid && bus_s_ready) begin
                    if (bitCnt_q == CW'(DATA_BITS - 1))
                        state_d = DONE;
                    else
                        bitCnt_d = bitCnt_q + 1'b1;
                end
            end
            WAIT_ACK: begin
                if (bus_s_ack)
                    state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort)
            state_d = DONE;
        if (state_d != state_q)
            bitCnt_d = '0;
        if (state_d == DONE && state_q != DONE)
            lastM2_d = ownerM2_q;

        // Outputs are decoded from the next state so they register alongside it.
        m1Grant_d = (state_d inside {ADDR, WDATA, RDATA, WAIT_ACK}) && !ownerM2_d;
        m2Grant_d = (state_d inside {ADDR, WDATA, RDATA, WAIT_ACK}) &&  ownerM2_d;
        mode_d    = state_d inside {WDATA, RDATA, WAIT_ACK};
        m1Done_d  = (state_d == DONE) && !ownerM2_d;
        m2Done_d  = (state_d == DONE) &&  ownerM2_d;
        err_d     = abort;
        busy_d    = (state_d != IDLE);
    end

`ifdef ARB_TIMEOUT_EN
    always_comb begin
        tmo_d = tmo_q + 1'b1;
        if (state_d != state_q || progress)
            tmo_d = '0;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bitCnt_q  <= '0;
            rw_q      <= 1'b0;
            ownerM2_q <= 1'b0;
            lastM2_q  <= 1'b1;
            m1Grant_q <= 1'b0;
            m2Grant_q <= 1'b0;
            mode_q    <= 1'b0;
            m1Done_q  <= 1'b0;
            m2Done_q  <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            tmo_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            bitCnt_q  <= bitCnt_d;
            rw_q      <= rw_d;
            ownerM2_q <= ownerM2_d;
            lastM2_q  <= lastM2_d;
            m1Grant_q <= m1Grant_d;
            m2Grant_q <= m2Grant_d;
            mode_q    <= mode_d;
            m1Done_q  <= m1Done_d;
            m2Done_q  <= m2Done_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
`ifdef ARB_TIMEOUT_EN
            tmo_q     <= tmo_d;
`endif
        end
    end

    assign m1_grant = m1Grant_q;
    assign m2_grant = m2Grant_q;
    assign bus_mode = mode_q;
    assign m1_done  = m1Done_q;
    assign m2_done  = m2Done_q;
    assign arb_err  = err_q;
    assign busy     = busy_q;

endmodule
